// File: rtl/game_step_sequencer.sv
// Frame-rate scheduler: issues one engine start per frame tick, waits for completion
// or timeout, and publishes ready/timeout/busy plus overrun and step counts on eoc.
module game_step_sequencer #(
   parameter int TICK_CYCLES    = 833333,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int CW             = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        ack,
   input  logic        eng_done,
   output logic        eng_start,
   output logic        frame_tick,
   output logic [31:0] eoc
);

   localparam int RW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_RUN} state_t;

   state_t         r_state;
   state_t         w_state_next;
   logic [CW-1:0]  r_tick_cnt;
   logic [RW-1:0]  r_run_cnt;
   logic [RW-1:0]  w_run_next;
   logic           r_frame_tick;
   logic           r_eng_start;
   logic           r_ready;
   logic           r_timeout;
   logic           r_busy;
   logic [7:0]     r_ovr_cnt;
   logic [15:0]    r_step_cnt;
   logic           w_ready_next;
   logic           w_timeout_next;
   logic           w_ovr_inc;
   logic           w_step_inc;
   logic           w_tick_hit;

   assign w_tick_hit = enable && (r_tick_cnt == CW'(TICK_CYCLES - 1));

   // enable low overrides everything: abort to IDLE, keep sticky flags and counts.
   always_comb begin
      w_state_next   = r_state;
      w_run_next     = r_run_cnt;
      w_ready_next   = r_ready;
      w_timeout_next = r_timeout;
      w_ovr_inc      = 1'b0;
      w_step_inc     = 1'b0;
      if (ack) begin
         w_ready_next   = 1'b0;
         w_timeout_next = 1'b0;
      end
      if (!enable) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: w_state_next = S_WAIT;
            S_WAIT: begin
               if (r_frame_tick) begin
                  if (r_ready) w_ovr_inc = 1'b1;
                  else         w_state_next = S_ISSUE;
               end
            end
            S_ISSUE: begin
               w_run_next   = '0;
               w_state_next = S_RUN;
               w_ovr_inc    = r_frame_tick;
            end
            S_RUN: begin
               w_ovr_inc = r_frame_tick;
               if (eng_done) begin
                  w_ready_next   = 1'b1;
                  w_timeout_next = 1'b0;
                  w_step_inc     = 1'b1;
                  w_state_next   = S_WAIT;
               end else if (r_run_cnt == RW'(TIMEOUT_CYCLES - 1)) begin
                  w_ready_next   = 1'b1;
                  w_timeout_next = 1'b1;
                  w_state_next   = S_WAIT;
               end else begin
                  w_run_next = r_run_cnt + 1'b1;
               end
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_tick_cnt   <= '0;
         r_run_cnt    <= '0;
         r_frame_tick <= 1'b0;
         r_eng_start  <= 1'b0;
         r_ready      <= 1'b0;
         r_timeout    <= 1'b0;
         r_busy       <= 1'b0;
         r_ovr_cnt    <= '0;
         r_step_cnt   <= '0;
      end else begin
         r_state      <= w_state_next;
         r_run_cnt    <= w_run_next;
         r_frame_tick <= w_tick_hit;
         r_eng_start  <= (w_state_next == S_ISSUE);
         r_busy       <= (w_state_next == S_ISSUE) || (w_state_next == S_RUN);
         r_ready      <= w_ready_next;
         r_timeout    <= w_timeout_next;
         r_step_cnt   <= r_step_cnt + {15'd0, w_step_inc};
         if (!enable || w_tick_hit) r_tick_cnt <= '0;
         else                       r_tick_cnt <= r_tick_cnt + 1'b1;
         if (w_ovr_inc && (r_ovr_cnt != 8'hFF)) r_ovr_cnt <= r_ovr_cnt + 1'b1;
      end
   end

   assign eng_start  = r_eng_start;
   assign frame_tick = r_frame_tick;
   assign eoc        = {r_step_cnt, r_ovr_cnt, 5'd0, r_busy, r_timeout, r_ready};

endmodule

// File: tb/tb_game_step_sequencer.sv
// Directed bench for game_step_sequencer with a 10-cycle frame and 6-cycle timeout;
// cycle numbers are counted from the cycle in which enable is raised.
module tb_game_step_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        ack = 1'b0;
   logic        eng_done = 1'b0;
   logic        eng_start;
   logic        frame_tick;
   logic [31:0] eoc;

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;

   game_step_sequencer #(.TICK_CYCLES(10), .TIMEOUT_CYCLES(6), .CW(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .ack        (ack),
      .eng_done   (eng_done),
      .eng_start  (eng_start),
      .frame_tick (frame_tick),
      .eoc        (eoc)
   );

   always #5 clock = ~clock;

   task automatic adv_to(input int target);
      while (cyc < target) begin
         @(posedge clock);
         #1;
         cyc++;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      chk("reset_eoc", eoc, 32'h0);
      chk("reset_tick", {31'd0, frame_tick}, 32'h0);
      chk("reset_start", {31'd0, eng_start}, 32'h0);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // 1: first frame and a completed step
      cyc = 0;
      enable = 1'b1;
      adv_to(9);
      chk("s1_tick_c9", {31'd0, frame_tick}, 32'h0);
      adv_to(10);
      chk("s1_tick_c10", {31'd0, frame_tick}, 32'h1);
      chk("s1_start_c10", {31'd0, eng_start}, 32'h0);
      adv_to(11);
      chk("s1_start_c11", {31'd0, eng_start}, 32'h1);
      chk("s1_busy_c11", eoc, 32'h0000_0004);
      adv_to(12);
      chk("s1_start_c12", {31'd0, eng_start}, 32'h0);
      adv_to(14);
      eng_done = 1'b1;
      adv_to(15);
      eng_done = 1'b0;
      chk("s1_done_eoc", eoc, 32'h0001_0001);

      // 2: unacknowledged tick overruns; after ack the next tick issues
      adv_to(21);
      chk("s2_no_start", {31'd0, eng_start}, 32'h0);
      chk("s2_ovr1", eoc, 32'h0001_0101);
      adv_to(22);
      ack = 1'b1;
      adv_to(23);
      ack = 1'b0;
      chk("s2_ack_clr", eoc, 32'h0001_0100);
      adv_to(31);
      chk("s2_start", {31'd0, eng_start}, 32'h1);
      chk("s2_busy", eoc, 32'h0001_0104);
      adv_to(33);
      chk("s2_run_nrdy", eoc, 32'h0001_0104);

      // 3: timeout after six RUN cycles, then a late done is ignored
      adv_to(37);
      chk("s3_last_run", eoc, 32'h0001_0104);
      adv_to(38);
      chk("s3_timeout", eoc, 32'h0001_0103);
      eng_done = 1'b1;
      adv_to(39);
      eng_done = 1'b0;
      chk("s3_late_done", eoc, 32'h0001_0103);
      adv_to(41);
      chk("s3_ovr2", eoc, 32'h0001_0203);
      ack = 1'b1;
      adv_to(42);
      ack = 1'b0;
      chk("s3_ack", eoc, 32'h0001_0200);

      // 4: ack and done together in RUN
      adv_to(51);
      chk("s4_start", {31'd0, eng_start}, 32'h1);
      adv_to(53);
      ack = 1'b1;
      eng_done = 1'b1;
      adv_to(54);
      ack = 1'b0;
      eng_done = 1'b0;
      chk("s4_done_wins", eoc, 32'h0002_0201);
      ack = 1'b1;
      adv_to(55);
      ack = 1'b0;
      chk("s4_ack", eoc, 32'h0002_0200);

      // 6a: drop enable in the second RUN cycle
      adv_to(61);
      chk("s6a_start", {31'd0, eng_start}, 32'h1);
      adv_to(63);
      enable = 1'b0;
      adv_to(64);
      chk("s6a_abort", eoc, 32'h0002_0200);
      chk("s6a_nostart", {31'd0, eng_start}, 32'h0);
      adv_to(71);
      chk("s6a_notick", {31'd0, frame_tick}, 32'h0);
      chk("s6a_idle", eoc, 32'h0002_0200);

      // 6b: reset mid-RUN
      cyc = 0;
      enable = 1'b1;
      adv_to(11);
      chk("s6b_start", {31'd0, eng_start}, 32'h1);
      adv_to(13);
      reset = 1'b1;
      adv_to(14);
      chk("s6b_rst_eoc", eoc, 32'h0);
      chk("s6b_rst_tick", {31'd0, frame_tick}, 32'h0);
      chk("s6b_rst_start", {31'd0, eng_start}, 32'h0);
      reset = 1'b0;
      cyc = 0;
      for (int i = 1; i <= 10; i++) begin
         adv_to(i);
         chk("s6b_quiet", {31'd0, eng_start}, 32'h0);
      end
      chk("s6b_tick", {31'd0, frame_tick}, 32'h1);

      // 5: engine never answers -> overrun saturates; then step count wrap
      adv_to(11);
      chk("s5_start", {31'd0, eng_start}, 32'h1);
      adv_to(18);
      chk("s5_timeout", eoc, 32'h0000_0003);
      adv_to(21);
      chk("s5_ovr1", eoc, 32'h0000_0103);
      adv_to(2551);
      chk("s5_ovr254", eoc, 32'h0000_FE03);
      adv_to(2561);
      chk("s5_ovr255", eoc, 32'h0000_FF03);
      adv_to(3001);
      chk("s5_ovr_sat", eoc, 32'h0000_FF03);
      force dut.r_step_cnt = 16'hFFFF;
      #1;
      release dut.r_step_cnt;
      ack = 1'b1;
      adv_to(3002);
      ack = 1'b0;
      chk("s5_preset", eoc, 32'hFFFF_FF00);
      adv_to(3011);
      chk("s5_wrap_start", {31'd0, eng_start}, 32'h1);
      adv_to(3013);
      eng_done = 1'b1;
      adv_to(3014);
      eng_done = 1'b0;
      chk("s5_wrap", eoc, 32'h0000_FF01);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
